// File: rtl/comparator_scan_controller.sv
// Comparator scan sequencer: per halfstrip it clears, settles, fires the injector and samples its error counts.
// Define SCAN_SUMMARY_EN to add the sum_thr / worst_hs scan summary outputs.
module comparator_scan_controller #(
  parameter int          FIRE_HOLD     = 12,
  parameter int          SETTLE_CYCLES = 8,
  parameter int          DRAIN_CYCLES  = 3,
  parameter logic [15:0] TIMEOUT       = 16'd4000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  hs_first,
  input  logic [4:0]  hs_last,
  input  logic [11:0] pulses_per_strip,
  input  logic        pulser_ready,
  input  logic [15:0] thresholds_errcnt,
  input  logic [15:0] offsets_errcnt,
  input  logic [15:0] compout_errcnt,
  output logic [4:0]  active_halfstrip,
  output logic        halfstrip_mask_en,
  output logic        fire_pulse,
  output logic [11:0] num_pulses,
  output logic        errcnt_rst,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        result_valid,
  output logic [4:0]  result_hs,
  output logic [15:0] result_thr,
  output logic [15:0] result_off,
  output logic [15:0] result_cmp
`ifdef SCAN_SUMMARY_EN
  ,
  output logic [23:0] sum_thr,
  output logic [4:0]  worst_hs
`endif
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, SETTLE, FIRE, WAIT_BUSY, WAIT_READY, DRAIN, REPORT, NEXT, FINISH
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [15:0] FIRE_LAST   = 16'((FIRE_HOLD > 1) ? FIRE_HOLD - 1 : 0);
  localparam logic [15:0] DRAIN_LAST  = 16'((DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [15:0] WDOG_LAST   = (TIMEOUT > 16'd1) ? TIMEOUT - 16'd1 : 16'd0;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  hs_q, hs_d, hs_last_q, hs_last_d;
  logic [11:0] num_q, num_d;
  logic        terr_q, terr_d, forced_q, forced_d, rv_q, rv_d;
  logic [4:0]  res_hs_q, res_hs_d;
  logic [15:0] res_thr_q, res_thr_d, res_off_q, res_off_d, res_cmp_q, res_cmp_d;
  logic [1:0]  rst_sync_q;
  logic        run, scan_start, report_go;
  logic [15:0] thr_s;

  // Reset release takes two edges to reach the FSM, so nothing moves on the release edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run = rst_sync_q[1];

  assign scan_start = (state_q == IDLE) && start && !abort;
  assign report_go  = (state_q == REPORT) && !abort;
  assign thr_s      = forced_q ? 16'hFFFF : thresholds_errcnt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hs_d      = hs_q;
    hs_last_d = hs_last_q;
    num_d     = num_q;
    terr_d    = terr_q;
    forced_d  = forced_q;
    rv_d      = 1'b0;
    res_hs_d  = res_hs_q;
    res_thr_d = res_thr_q;
    res_off_d = res_off_q;
    res_cmp_d = res_cmp_q;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (scan_start) begin
          state_d   = CLEAR;
          hs_d      = hs_first;
          hs_last_d = hs_last;
          num_d     = (pulses_per_strip == 12'd0) ? 12'd1 : pulses_per_strip;
          terr_d    = 1'b0;
          forced_d  = 1'b0;
          cnt_d     = '0;
        end
        CLEAR: begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
        SETTLE: if (cnt_q >= SETTLE_LAST) begin
          state_d = FIRE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
        FIRE: if (cnt_q >= FIRE_LAST) begin
          state_d  = WAIT_BUSY;
          cnt_d    = '0;
          forced_d = 1'b0;
        end else cnt_d = cnt_q + 16'd1;
        // The watchdog spans both wait states and wins over a coincident ready edge.
        WAIT_BUSY: if (cnt_q >= WDOG_LAST) begin
          state_d  = REPORT;
          terr_d   = 1'b1;
          forced_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (!pulser_ready) state_d = WAIT_READY;
        end
        WAIT_READY: if (cnt_q >= WDOG_LAST) begin
          state_d  = REPORT;
          terr_d   = 1'b1;
          forced_d = 1'b1;
          cnt_d    = '0;
        end else if (pulser_ready) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
        DRAIN: if (cnt_q >= DRAIN_LAST) begin
          state_d = REPORT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
        REPORT: begin
          state_d   = NEXT;
          rv_d      = 1'b1;
          res_hs_d  = hs_q;
          res_thr_d = thr_s;
          res_off_d = forced_q ? 16'hFFFF : offsets_errcnt;
          res_cmp_d = forced_q ? 16'hFFFF : compout_errcnt;
        end
        NEXT: if (hs_q == hs_last_q) state_d = FINISH;
        else begin
          hs_d    = hs_q + 5'd1;
          state_d = CLEAR;
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hs_q      <= '0;
      hs_last_q <= '0;
      num_q     <= '0;
      terr_q    <= 1'b0;
      forced_q  <= 1'b0;
      rv_q      <= 1'b0;
      res_hs_q  <= '0;
      res_thr_q <= '0;
      res_off_q <= '0;
      res_cmp_q <= '0;
    end else if (run) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hs_q      <= hs_d;
      hs_last_q <= hs_last_d;
      num_q     <= num_d;
      terr_q    <= terr_d;
      forced_q  <= forced_d;
      rv_q      <= rv_d;
      res_hs_q  <= res_hs_d;
      res_thr_q <= res_thr_d;
      res_off_q <= res_off_d;
      res_cmp_q <= res_cmp_d;
    end
  end

  assign active_halfstrip  = hs_q;
  assign halfstrip_mask_en = (state_q != IDLE);
  assign busy              = (state_q != IDLE);
  assign fire_pulse        = (state_q == FIRE);
  assign errcnt_rst        = (state_q == CLEAR);
  assign done              = (state_q == FINISH);
  assign num_pulses        = num_q;
  assign timeout_err       = terr_q;
  assign result_valid      = rv_q;
  assign result_hs         = res_hs_q;
  assign result_thr        = res_thr_q;
  assign result_off        = res_off_q;
  assign result_cmp        = res_cmp_q;

`ifdef SCAN_SUMMARY_EN
  logic [23:0] sum_q, sum_d;
  logic [24:0] sum_wide;
  logic [15:0] wv_q, wv_d;
  logic [4:0]  whs_q, whs_d;
  logic        have_q, have_d;

  assign sum_wide = {1'b0, sum_q} + {9'd0, thr_s};

  // Strict greater-than keeps the earliest halfstrip on ties.
  always_comb begin
    sum_d  = sum_q;
    wv_d   = wv_q;
    whs_d  = whs_q;
    have_d = have_q;
    if (scan_start) begin
      sum_d  = '0;
      wv_d   = '0;
      whs_d  = hs_first;
      have_d = 1'b0;
    end else if (report_go) begin
      sum_d = sum_wide[24] ? 24'hFFFFFF : sum_wide[23:0];
      if (!have_q || (thr_s > wv_q)) begin
        wv_d   = thr_s;
        whs_d  = hs_q;
        have_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q  <= '0;
      wv_q   <= '0;
      whs_q  <= '0;
      have_q <= 1'b0;
    end else if (run) begin
      sum_q  <= sum_d;
      wv_q   <= wv_d;
      whs_q  <= whs_d;
      have_q <= have_d;
    end
  end

  assign sum_thr  = sum_q;
  assign worst_hs = whs_q;
`endif

endmodule

// File: tb/tb_comparator_scan_controller.sv
// Bench for comparator_scan_controller: injector model, per-scan result model, cycle monitor, directed + random scans.
module tb_comparator_scan_controller;

  localparam int          TB_FIRE   = 12;
  localparam int          TB_SETTLE = 8;
  localparam int          TB_DRAIN  = 3;
  localparam logic [15:0] TB_TO     = 16'd60;

  logic        clock, reset_n, start, abort, pulser_ready;
  logic [4:0]  hs_first, hs_last;
  logic [11:0] pulses_per_strip;
  logic [15:0] thresholds_errcnt, offsets_errcnt, compout_errcnt;
  logic [4:0]  active_halfstrip, result_hs;
  logic        halfstrip_mask_en, fire_pulse, errcnt_rst, busy, done, timeout_err, result_valid;
  logic [11:0] num_pulses;
  logic [15:0] result_thr, result_off, result_cmp;
`ifdef SCAN_SUMMARY_EN
  logic [23:0] sum_thr;
  logic [4:0]  worst_hs;
`endif

  int          tot_cnt = 0;
  int          pass_cnt = 0;
  logic [52:0] exp_q[$];
  logic [4:0]  obs_hs[$];
  logic [15:0] obs_thr[$];
  logic [15:0] tbl_thr[32], tbl_off[32], tbl_cmp[32];
  logic [11:0] exp_num;
  bit          mon_en = 0, aborting = 0, inj_stuck = 0;
  int          exp_sum;
  logic [4:0]  exp_worst;

  comparator_scan_controller #(
    .FIRE_HOLD(TB_FIRE), .SETTLE_CYCLES(TB_SETTLE), .DRAIN_CYCLES(TB_DRAIN), .TIMEOUT(TB_TO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .hs_first(hs_first), .hs_last(hs_last), .pulses_per_strip(pulses_per_strip),
    .pulser_ready(pulser_ready), .thresholds_errcnt(thresholds_errcnt),
    .offsets_errcnt(offsets_errcnt), .compout_errcnt(compout_errcnt),
    .active_halfstrip(active_halfstrip), .halfstrip_mask_en(halfstrip_mask_en),
    .fire_pulse(fire_pulse), .num_pulses(num_pulses), .errcnt_rst(errcnt_rst),
    .busy(busy), .done(done), .timeout_err(timeout_err), .result_valid(result_valid),
    .result_hs(result_hs), .result_thr(result_thr), .result_off(result_off),
    .result_cmp(result_cmp)
`ifdef SCAN_SUMMARY_EN
    , .sum_thr(sum_thr), .worst_hs(worst_hs)
`endif
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Injector: after fire ends, goes not-ready for a while, then presents the halfstrip's counts.
  initial begin
    int ph, t;
    ph = 0; t = 0;
    pulser_ready = 1'b1;
    thresholds_errcnt = '0; offsets_errcnt = '0; compout_errcnt = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        ph = 0;
        pulser_ready = 1'b1;
        thresholds_errcnt = '0; offsets_errcnt = '0; compout_errcnt = '0;
      end else begin
        if (errcnt_rst) begin
          thresholds_errcnt = '0; offsets_errcnt = '0; compout_errcnt = '0;
        end
        case (ph)
          0: if (fire_pulse) ph = 1;
          1: if (!fire_pulse) begin
            ph = inj_stuck ? 0 : 2;
            t  = int'($urandom_range(0, 3));
          end
          2: if (t == 0) begin
            pulser_ready = 1'b0;
            t  = int'($urandom_range(1, 6));
            ph = 3;
          end else t--;
          3: if (t == 0) begin
            thresholds_errcnt = tbl_thr[active_halfstrip];
            offsets_errcnt    = tbl_off[active_halfstrip];
            compout_errcnt    = tbl_cmp[active_halfstrip];
            pulser_ready = 1'b1;
            ph = 0;
          end else t--;
          default: ph = 0;
        endcase
      end
    end
  end

  // Monitor / scoreboard: checks every result pulse and the fire/settle/watchdog timing.
  initial begin
    logic        prev_fire;
    int          fire_run, gap, wd;
    logic [52:0] e;
    prev_fire = 1'b0; fire_run = 0; gap = 0; wd = 0;
    forever begin
      @(negedge clock);
      if (errcnt_rst) gap = 0; else gap++;
      if (fire_pulse) fire_run++;
      if (prev_fire && !fire_pulse) wd = 0; else wd++;
      if (mon_en) begin
        if (fire_pulse && !prev_fire) chk("settle_gap", 64'(gap), 64'(TB_SETTLE + 1));
        if (prev_fire && !fire_pulse && !aborting) chk("fire_hold", 64'(fire_run), 64'(TB_FIRE));
        if (result_valid) begin
          obs_hs.push_back(result_hs);
          obs_thr.push_back(result_thr);
          if (exp_q.size() == 0) chk("unexpected_result", 64'(result_hs), 64'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("result_hs",  64'(result_hs),  64'(e[52:48]));
            chk("result_thr", 64'(result_thr), 64'(e[47:32]));
            chk("result_off", 64'(result_off), 64'(e[31:16]));
            chk("result_cmp", 64'(result_cmp), 64'(e[15:0]));
          end
          if (inj_stuck) chk("watchdog_cycles", 64'(wd), 64'(int'(TB_TO) + 1));
        end
        if (done) chk("done_after_all_results", 64'(exp_q.size()), 64'd0);
      end
      if (!fire_pulse) fire_run = 0;
      prev_fire = fire_pulse;
    end
  end

  // Driver: builds the expected result list for a scan, runs it, scrambles inputs while busy.
  task automatic run_scan(input logic [4:0] f, input logic [4:0] l, input logic [11:0] p,
                          input bit stuck, input bit rand_tbl);
    logic [4:0]  h;
    logic [15:0] thr, off, cmp;
    bit          got_done, first;
    inj_stuck = stuck;
    if (rand_tbl) begin
      for (int i = 0; i < 32; i++) begin
        tbl_thr[i] = 16'($urandom); tbl_off[i] = 16'($urandom); tbl_cmp[i] = 16'($urandom);
      end
    end
    exp_q.delete(); obs_hs.delete(); obs_thr.delete();
    exp_num = (p == 12'd0) ? 12'd1 : p;
    exp_sum = 0; exp_worst = f; first = 1'b1;
    h = f;
    for (int k = 0; k < 32; k++) begin
      thr = stuck ? 16'hFFFF : tbl_thr[h];
      off = stuck ? 16'hFFFF : tbl_off[h];
      cmp = stuck ? 16'hFFFF : tbl_cmp[h];
      exp_q.push_back({h, thr, off, cmp});
      exp_sum = exp_sum + int'(thr);
      if (exp_sum > 24'hFFFFFF) exp_sum = 24'hFFFFFF;
      if (first || thr > tbl_thr_max(exp_q)) exp_worst = h;
      first = 1'b0;
      if (h == l) break;
      h = h + 5'd1;
    end
    hs_first = f; hs_last = l; pulses_per_strip = p; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_clears_timeout_err", 64'(timeout_err), 64'd0);
    got_done = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      chk("busy_mask_num", 64'({busy, halfstrip_mask_en, num_pulses}), 64'({2'b11, exp_num}));
      hs_first = 5'($urandom); hs_last = 5'($urandom);
      pulses_per_strip = 12'($urandom); start = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    start = 1'b0;
    chk("done_seen", 64'(got_done), 64'd1);
    if (!got_done) begin
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
    end
    @(negedge clock);
    chk("idle_after_done", 64'({busy, done, halfstrip_mask_en}), 64'd0);
    chk("timeout_err_sticky", 64'(timeout_err), 64'(stuck));
`ifdef SCAN_SUMMARY_EN
    chk("sum_thr", 64'(sum_thr), 64'(exp_sum));
    chk("worst_hs", 64'(worst_hs), 64'(exp_worst));
`endif
  endtask

  // Highest threshold seen before the newest entry; earlier halfstrips win ties.
  function automatic logic [15:0] tbl_thr_max(input logic [52:0] q[$]);
    logic [15:0] m;
    m = 16'd0;
    for (int i = 0; i + 1 < q.size(); i++) if (q[i][47:32] > m) m = q[i][47:32];
    return m;
  endfunction

  initial begin
    logic [4:0]  f, l;
    logic [11:0] p;
    bit          got, any;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    hs_first = '0; hs_last = '0; pulses_per_strip = '0;
    for (int i = 0; i < 32; i++) begin
      tbl_thr[i] = '0; tbl_off[i] = '0; tbl_cmp[i] = '0;
    end
    repeat (3) @(negedge clock);
    chk("reset_ctrl", 64'({active_halfstrip, halfstrip_mask_en, fire_pulse, num_pulses, errcnt_rst,
                           busy, done, timeout_err, result_valid, result_hs}), 64'd0);
    chk("reset_results", 64'({result_thr, result_off, result_cmp}), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    mon_en = 1'b1;

    // three halfstrips, thresholds 0,1,0
    tbl_thr[3] = 16'd0; tbl_thr[4] = 16'd1; tbl_thr[5] = 16'd0;
    tbl_off[4] = 16'h0042; tbl_cmp[5] = 16'h0007;
    run_scan(5'd3, 5'd5, 12'd2, 1'b0, 1'b0);
    chk("lit_count_3", 64'(obs_hs.size()), 64'd3);
    chk("lit_hs_345", 64'({obs_hs[0], obs_hs[1], obs_hs[2]}), 64'({5'd3, 5'd4, 5'd5}));
    chk("lit_thr_010", 64'({obs_thr[0], obs_thr[1], obs_thr[2]}), 64'({16'd0, 16'd1, 16'd0}));

    // wrap 30 -> 1
    run_scan(5'd30, 5'd1, 12'd7, 1'b0, 1'b1);
    chk("lit_wrap_count", 64'(obs_hs.size()), 64'd4);
    chk("lit_wrap_hs", 64'({obs_hs[0], obs_hs[1], obs_hs[2], obs_hs[3]}),
        64'({5'd30, 5'd31, 5'd0, 5'd1}));

    // single halfstrip with zero pulses requested
    run_scan(5'd12, 5'd12, 12'd0, 1'b0, 1'b1);
    chk("lit_single_count", 64'(obs_hs.size()), 64'd1);
    chk("lit_pps0_num", 64'(num_pulses), 64'd1);

`ifdef SCAN_SUMMARY_EN
    tbl_thr[10] = 16'd5; tbl_thr[11] = 16'd9; tbl_thr[12] = 16'd9;
    run_scan(5'd10, 5'd12, 12'd3, 1'b0, 1'b0);
    chk("lit_sum_23", 64'(sum_thr), 64'd23);
    chk("lit_worst_11", 64'(worst_hs), 64'd11);
`endif

    for (int k = 0; k < 6; k++) begin
      f = 5'($urandom_range(0, 31));
      l = 5'(f + 5'($urandom_range(0, 9)));
      p = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      run_scan(f, l, p, 1'b0, 1'b1);
    end

    // abort beats start in idle
    hs_first = 5'd2; hs_last = 5'd4; start = 1'b1; abort = 1'b1;
    @(negedge clock);
    chk("abort_beats_start", 64'(busy), 64'd0);
    start = 1'b0; abort = 1'b0;

    // abort during fire
    aborting = 1'b1; inj_stuck = 1'b0; exp_q.delete();
    hs_first = 5'd0; hs_last = 5'd31; pulses_per_strip = 12'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (fire_pulse) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk("fire_reached", 64'(got), 64'd1);
    repeat (3) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    chk("abort_clears", 64'({fire_pulse, busy, halfstrip_mask_en, done, result_valid}), 64'd0);
    abort = 1'b0;
    any = 1'b0;
    repeat (30) begin
      @(negedge clock);
      any = any | done | busy | result_valid;
    end
    chk("idle_after_abort", 64'(any), 64'd0);
    aborting = 1'b0;

    // stuck-ready injector trips the watchdog on every halfstrip, scan still completes
    run_scan(5'd8, 5'd9, 12'd4, 1'b1, 1'b1);
    chk("lit_timeout_thr", 64'(result_thr), 64'hFFFF);
    chk("lit_timeout_flag", 64'(timeout_err), 64'd1);

    // asynchronous reset mid-scan
    mon_en = 1'b0; inj_stuck = 1'b0;
    hs_first = 5'd7; hs_last = 5'd20; pulses_per_strip = 12'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (15) @(negedge clock);
    chk("midscan_busy_num", 64'({busy, num_pulses}), 64'({1'b1, 12'd1}));
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 64'({active_halfstrip, halfstrip_mask_en, fire_pulse, num_pulses, errcnt_rst,
                                 busy, done, timeout_err, result_valid, result_hs}), 64'd0);
    chk("async_reset_results", 64'({result_thr, result_off, result_cmp}), 64'd0);
    repeat (2) @(negedge clock);
    hs_first = 5'd0; hs_last = 5'd0; start = 1'b1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("no_move_on_release", 64'(busy), 64'd0);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("idle_after_release", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
